// File: rtl/wptr_ctrl.sv
// Write-side pointer controller for the asynchronous byte FIFO: binary/Gray write
// pointers, read-pointer synchronizer, registered full/almost-full/level, sticky overflow.
module wptr_ctrl #(
  parameter int PTR_WIDTH = 4,
  parameter int AF_THRESH = 6
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 w_en,
  input  logic                 ovf_clr,
  input  logic [PTR_WIDTH-1:0] g_rptr,
  output logic [PTR_WIDTH-1:0] b_wptr,
  output logic [PTR_WIDTH-1:0] g_wptr,
  output logic [PTR_WIDTH-2:0] waddr,
  output logic                 w_ack,
  output logic                 full,
  output logic                 almost_full,
  output logic [PTR_WIDTH-1:0] wlevel,
  output logic                 overflow
);

  localparam logic [PTR_WIDTH-1:0] AF_LEVEL = AF_THRESH[PTR_WIDTH-1:0];

  logic [PTR_WIDTH-1:0] rq1_reg;
  logic [PTR_WIDTH-1:0] rq2_reg;
  logic [PTR_WIDTH-1:0] b_rptr_sync;

  logic [PTR_WIDTH-1:0] b_wptr_reg;
  logic [PTR_WIDTH-1:0] g_wptr_reg;
  logic                 full_reg;
  logic                 almost_full_reg;
  logic [PTR_WIDTH-1:0] wlevel_reg;
  logic                 overflow_reg;

  logic [PTR_WIDTH-1:0] b_wptr_next;
  logic [PTR_WIDTH-1:0] g_wptr_next;
  logic [PTR_WIDTH-1:0] full_match;
  logic                 full_next;
  logic [PTR_WIDTH-1:0] level_next;
  logic                 almost_full_next;
  logic                 overflow_next;

  // Two-flop synchronizer for the asynchronous Gray read pointer
  always_ff @(posedge wclk) begin
    if (wrst) begin
      rq1_reg <= '0;
      rq2_reg <= '0;
    end else begin
      rq1_reg <= g_rptr;
      rq2_reg <= rq1_reg;
    end
  end

  // Each binary bit is the XOR of all Gray bits at or above it
  genvar gi;
  generate
    for (gi = 0; gi < PTR_WIDTH; gi++) begin : g_gray2bin
      assign b_rptr_sync[gi] = ^rq2_reg[PTR_WIDTH-1:gi];
    end
  endgenerate

  assign w_ack       = w_en & ~full_reg;
  assign b_wptr_next = b_wptr_reg + {{(PTR_WIDTH-1){1'b0}}, w_ack};
  assign g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next;

  // Full when the write pointer has lapped the read pointer: top two Gray bits inverted
  assign full_match = {~rq2_reg[PTR_WIDTH-1:PTR_WIDTH-2], rq2_reg[PTR_WIDTH-3:0]};
  assign full_next  = (g_wptr_next == full_match);

  assign level_next       = b_wptr_next - b_rptr_sync;
  assign almost_full_next = (level_next >= AF_LEVEL);

  always_comb begin
    overflow_next = overflow_reg;
    if (w_en & full_reg) begin
      overflow_next = 1'b1;
    end else if (ovf_clr) begin
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      b_wptr_reg      <= '0;
      g_wptr_reg      <= '0;
      full_reg        <= 1'b0;
      almost_full_reg <= 1'b0;
      wlevel_reg      <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      b_wptr_reg      <= b_wptr_next;
      g_wptr_reg      <= g_wptr_next;
      full_reg        <= full_next;
      almost_full_reg <= almost_full_next;
      wlevel_reg      <= level_next;
      overflow_reg    <= overflow_next;
    end
  end

  assign b_wptr      = b_wptr_reg;
  assign g_wptr      = g_wptr_reg;
  assign waddr       = b_wptr_reg[PTR_WIDTH-2:0];
  assign full        = full_reg;
  assign almost_full = almost_full_reg;
  assign wlevel      = wlevel_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_wptr_ctrl.sv
// Directed bench for wptr_ctrl: occupancy-count model checked every cycle plus
// literal expectations for reset, fill, release, wrap, overflow priority and mid-fill reset.
module tb_wptr_ctrl;

  logic       wclk;
  logic       wrst;
  logic       w_en;
  logic       ovf_clr;
  logic [3:0] g_rptr;
  logic [3:0] b_wptr;
  logic [3:0] g_wptr;
  logic [2:0] waddr;
  logic       w_ack;
  logic       full;
  logic       almost_full;
  logic [3:0] wlevel;
  logic       overflow;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  wptr_ctrl #(.PTR_WIDTH(4), .AF_THRESH(6)) dut (
    .wclk        (wclk),
    .wrst        (wrst),
    .w_en        (w_en),
    .ovf_clr     (ovf_clr),
    .g_rptr      (g_rptr),
    .b_wptr      (b_wptr),
    .g_wptr      (g_wptr),
    .waddr       (waddr),
    .w_ack       (w_ack),
    .full        (full),
    .almost_full (almost_full),
    .wlevel      (wlevel),
    .overflow    (overflow)
  );

  initial wclk = 0;
  always #5 wclk = ~wclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] gray(input int v);
    int m;
    m = v & 15;
    return 4'(m ^ (m >> 1));
  endfunction

  function automatic int gray2bin(input int g);
    int r;
    r = g;
    for (int s = 1; s < 4; s++) r = r ^ (g >> s);
    return r & 15;
  endfunction

  // Model: write count, delayed read count, occupancy = difference mod 16
  int m_w = 0, m_r1 = 0, m_r2 = 0, m_lvl = 0;
  bit m_full = 0, m_af = 0, m_ovf = 0;

  always @(posedge wclk) begin
    int ack;
    int nw;
    int nl;
    if (wrst) begin
      m_w <= 0; m_r1 <= 0; m_r2 <= 0; m_lvl <= 0;
      m_full <= 0; m_af <= 0; m_ovf <= 0;
    end else begin
      ack = (w_en && !m_full) ? 1 : 0;
      nw  = (m_w + ack) % 16;
      nl  = (nw - gray2bin(m_r2) + 16) % 16;
      if (w_en && m_full) m_ovf <= 1;
      else if (ovf_clr)   m_ovf <= 0;
      m_w    <= nw;
      m_lvl  <= nl;
      m_full <= (nl == 8);
      m_af   <= (nl >= 6);
      m_r2   <= m_r1;
      m_r1   <= int'(g_rptr);
    end
  end

  always @(negedge wclk) begin
    if (chk_en) begin
      chk("model_b_wptr", b_wptr, m_w);
      chk("model_g_wptr", g_wptr, gray(m_w));
      chk("model_waddr", waddr, m_w % 8);
      chk("model_w_ack", w_ack, (w_en && !m_full) ? 1 : 0);
      chk("model_full", full, m_full);
      chk("model_almost_full", almost_full, m_af);
      chk("model_wlevel", wlevel, m_lvl);
      chk("model_overflow", overflow, m_ovf);
    end
  end

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  initial begin
    int lvl;
    int wcnt;
    logic [3:0] prev_g;
    bit saw_wrap;

    wrst = 1; w_en = 1; ovf_clr = 0; g_rptr = 4'b0000;
    step();
    chk_en = 1;
    step();
    $display("phase reset: b_wptr=%0d wlevel=%0d", b_wptr, wlevel);
    chk("rst_b_wptr", b_wptr, 0);
    chk("rst_g_wptr", g_wptr, 0);
    chk("rst_wlevel", wlevel, 0);
    chk("rst_full", full, 0);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_overflow", overflow, 0);

    wrst = 0;
    for (int i = 1; i <= 10; i++) begin
      #1;
      chk("fill_w_ack", w_ack, (i <= 8) ? 1 : 0);
      step();
      lvl = (i < 8) ? i : 8;
      $display("fill cycle %0d: b_wptr=%0d wlevel=%0d full=%0d af=%0d ovf=%0d",
               i, b_wptr, wlevel, full, almost_full, overflow);
      chk("fill_b_wptr", b_wptr, lvl);
      chk("fill_wlevel", wlevel, lvl);
      chk("fill_full", full, (i >= 8) ? 1 : 0);
      chk("fill_almost_full", almost_full, (lvl >= 6) ? 1 : 0);
      chk("fill_overflow", overflow, (i >= 9) ? 1 : 0);
    end
    chk("fill_g_wptr_final", g_wptr, 4'b1100);

    w_en = 0; g_rptr = 4'b0010;
    for (int k = 1; k <= 3; k++) begin
      step();
      $display("release edge %0d: full=%0d wlevel=%0d", k, full, wlevel);
      if (k < 3) begin
        chk("release_full_held", full, 1);
        chk("release_wlevel_held", wlevel, 8);
      end else begin
        chk("release_full", full, 0);
        chk("release_wlevel", wlevel, 5);
        chk("release_almost_full", almost_full, 0);
      end
    end

    ovf_clr = 1;
    step();
    chk("ovf_clear_idle", overflow, 0);
    ovf_clr = 0; w_en = 1;
    repeat (3) step();
    chk("refill_full", full, 1);
    chk("refill_wlevel", wlevel, 8);
    chk("refill_b_wptr", b_wptr, 11);
    #1;
    chk("refill_w_ack_blocked", w_ack, 0);
    step();
    chk("ovf_set", overflow, 1);
    chk("ovf_no_ptr_move", b_wptr, 11);
    ovf_clr = 1;
    step();
    $display("ovf priority: overflow=%0d", overflow);
    chk("ovf_set_beats_clear", overflow, 1);
    w_en = 0;
    step();
    chk("ovf_cleared", overflow, 0);
    ovf_clr = 0;

    g_rptr = gray(10);
    repeat (3) step();
    chk("wrap_pre_full", full, 0);
    chk("wrap_pre_wlevel", wlevel, 1);
    wcnt = 11; prev_g = g_wptr; saw_wrap = 0;
    for (int n = 0; n < 20; n++) begin
      w_en = 1; g_rptr = gray(wcnt);
      step();
      wcnt = (wcnt + 1) % 16;
      $display("wrap write %0d: b_wptr=%0d g_wptr=%b wlevel=%0d", n, b_wptr, g_wptr, wlevel);
      chk("wrap_b_wptr", b_wptr, wcnt);
      chk("wrap_no_full", full, 0);
      chk("wrap_wlevel_2_3", (wlevel == 2 || wlevel == 3) ? 1 : 0, 1);
      chk("wrap_gray_1bit", $countones(prev_g ^ g_wptr), 1);
      if (prev_g == 4'b1000 && g_wptr == 4'b0000) saw_wrap = 1;
      prev_g = g_wptr;
    end
    chk("wrap_seen", saw_wrap, 1);

    w_en = 0; wrst = 1; g_rptr = 4'b0000;
    step();
    wrst = 0; w_en = 1;
    repeat (5) step();
    chk("midfill_wlevel", wlevel, 5);
    wrst = 1;
    step();
    $display("midfill reset: b_wptr=%0d wlevel=%0d", b_wptr, wlevel);
    chk("midfill_b_wptr", b_wptr, 0);
    chk("midfill_g_wptr", g_wptr, 0);
    chk("midfill_wlevel0", wlevel, 0);
    chk("midfill_full", full, 0);
    chk("midfill_almost_full", almost_full, 0);
    chk("midfill_overflow", overflow, 0);
    wrst = 0;
    step();
    chk("postrst_b_wptr", b_wptr, 1);
    chk("postrst_g_wptr", g_wptr, 4'b0001);
    w_en = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wptr_ctrl.md
# wptr_ctrl

Write-side pointer controller for the UART controller's asynchronous byte FIFO; it is the counterpart of the read-pointer handler. It runs entirely in the write clock domain and contains the following:

- binary and Gray write pointers;
- a two-flop synchronizer for the incoming Gray read pointer, plus Gray-to-binary conversion;
- registered full, almost-full and fill-level outputs;
- a sticky overflow flag.

Its outputs drive the FIFO memory write port and, through the read-domain synchronizer, the read side's empty logic.

## Interface
- PTR_WIDTH, 4, pointer width including wrap bit; FIFO depth DEPTH = 2^(PTR_WIDTH-1), address = b_wptr[PTR_WIDTH-2:0]
- AF_THRESH, 6, almost_full asserts when level >= AF_THRESH; legal range 1..DEPTH
- wclk  in  1  write-domain clock, all state on rising edge
- wrst  in  1  synchronous, active-high reset
- w_en  in  1  write request from producer (UART RX datapath)
- ovf_clr  in  1  clears sticky overflow
- g_rptr  in  PTR_WIDTH  Gray read pointer from read domain (asynchronous, unsynchronized)
- b_wptr  out  PTR_WIDTH  binary write pointer
- g_wptr  out  PTR_WIDTH  Gray write pointer, registered, to read-domain synchronizer
- waddr  out  PTR_WIDTH-1  memory write address = b_wptr[PTR_WIDTH-2:0]
- w_ack  out  1  combinational w_en & !full; memory write enable
- full  out  1  registered full flag
- almost_full  out  1  registered level >= AF_THRESH
- wlevel  out  PTR_WIDTH  registered fill estimate, 0..DEPTH
- overflow  out  1  sticky: write attempted while full

## Operation
- Synchronizer: rq1 <= g_rptr; rq2 <= rq1; g_rptr_sync = rq2. Both stages reset to 0.
- Gray-to-binary: b_rptr_sync[i] = XOR of g_rptr_sync[PTR_WIDTH-1:i].
- Next-state terms:
  - b_wptr_next = b_wptr + w_ack, modulo 2^PTR_WIDTH.
  - g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next.
- Full, computed from next-state terms: full_next = (g_wptr_next == {~g_rptr_sync[PTR_WIDTH-1:PTR_WIDTH-2], g_rptr_sync[PTR_WIDTH-3:0]}).
- Level: level_next = b_wptr_next - b_rptr_sync, modulo 2^PTR_WIDTH. The value never exceeds DEPTH.
- Registered every edge: b_wptr, g_wptr, full, wlevel = level_next, almost_full = (level_next >= AF_THRESH).
- Write while full: produces no w_ack, no pointer change and no memory write.
- Overflow:
  - Set on an edge where w_en & full.
  - Cleared on an edge where ovf_clr & !(w_en & full).
  - Set has priority over clear.
- Reset (wrst high at an edge): b_wptr, g_wptr, rq1, rq2, wlevel = 0; full = 0, almost_full = 0, overflow = 0. Reset overrides w_en on the same edge.
- Reset mid-operation discards the pointers. The read domain must be reset in the same system reset event; if it is not, full and level are undefined until both sides are reset.
- Wrap-around:
  - Pointers roll over 2^PTR_WIDTH-1 -> 0.
  - Full and level use the wrap bit, so equal addresses with differing wrap bits mean full, never empty.
- Conservative flags: full and wlevel are pessimistic because the read pointer is delayed. Over-reporting full is legal; under-reporting is not.

## Timing
- Accepted write: w_ack high in cycle N. The memory is written at the edge ending cycle N. b_wptr, g_wptr, wlevel, full and almost_full all reflect the write from cycle N+1.
- Full: asserts at the same edge as the write that fills the FIFO. A w_en in the following cycle is refused.
- Read-pointer change: a stable change on g_rptr is visible in full, wlevel and almost_full 3 wclk edges later (2 synchronizer edges + 1 register edge).
- Latency: w_ack has zero-cycle latency (combinational). Overflow sets 1 edge after the offending cycle.
- Gray pointer: g_wptr changes at most 1 bit per edge.

## Test plan
- Reset: assert wrst for 2 edges with w_en=1.
  - Required: b_wptr=0, g_wptr=0, wlevel=0, full=0, almost_full=0, overflow=0, no w_ack-driven pointer movement.
- Fill with g_rptr=0 and w_en=1 for 10 cycles (PTR_WIDTH=4):
  - w_ack high for the first 8 cycles.
  - b_wptr steps 0..8; final g_wptr=4'b1100.
  - almost_full rises at the edge where wlevel becomes 6.
  - full rises at the edge where wlevel becomes 8.
  - Cycles 9-10 have w_ack=0; overflow=1 after cycle 9.
- Release from full: drive g_rptr=4'b0010 (binary 3).
  - full=0, wlevel=5, almost_full=0 exactly 3 edges later, not earlier.
- Wrap: read side tracks writes (g_rptr equals the Gray of writes minus 2 per cycle), then 20 writes.
  - b_wptr wraps 15->0 and g_wptr goes 4'b1000->4'b0000.
  - No false full; wlevel stays at 2 or 3.
- Overflow priority:
  - With full=1, w_en=1 and ovf_clr=1 on the same edge -> overflow stays 1.
  - Next cycle, w_en=0 and ovf_clr=1 -> overflow=0.
- Reset mid-fill: at wlevel=5 assert wrst for 1 edge with w_en=1.
  - All outputs return to reset values the next cycle.
  - The first write afterwards gives b_wptr=1 and g_wptr=4'b0001.
